bcd_serial_subtractor_4digit: RTL and testbench
===============================================

BCD_SERIAL_SUBTRACTOR_4DIGIT -- requirements
Module: bcd_serial_subtractor_4digit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a_4digit  input  16  minuend, 4 packed BCD digits, [3:0] = least significant digit.
REQ-006 b_4digit  input  16  subtrahend, same packing.
REQ-007 bin  input  1  borrow-in, subtracted at the least significant digit.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 diff_4digit  output  16  result, packed BCD; ten's-complement form when bout=1.
REQ-011 bout  output  1  borrow-out from the most significant digit (1 = a < b + bin).
REQ-012 err  output  1  high if any captured input digit was greater than 9.

Function
REQ-013 SHALL compute a - b - bin digit-serially, LSD first, one digit per clock.
REQ-014 FSM states SHALL be IDLE, SUB and DONE.
REQ-015 IDLE: when start=1, capture a_4digit, b_4digit and bin into internal registers, clear the digit index to 0, and go to SUB; when start=0, stay in IDLE.
REQ-016 SUB: each cycle, process digit i as t = a_i - b_i - borrow.
  - If t < 0: diff_i = t + 10, borrow = 1.
  - Else: diff_i = t, borrow = 0.
  - Write diff_i into diff_4digit[4i+3:4i] and increment i.
  - After i = 3, go to DONE.
REQ-017 The initial borrow SHALL be the captured bin.
REQ-018 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-019 Fixed latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+5 (4 SUB cycles, then DONE).
REQ-020 busy SHALL be 1 in SUB and DONE and 0 in IDLE.
REQ-021 start SHALL be ignored in SUB and DONE: no recapture and no effect on the result.
REQ-022 diff_4digit, bout and err SHALL hold their values from the end of DONE until the next accepted start.
REQ-023 At capture, err SHALL be set if any digit of a or b is greater than 9, and cleared otherwise.
REQ-024 When err=1, the FSM SHALL still take the full latency, but at DONE diff_4digit SHALL be 16'h0000 and bout SHALL be 0.
REQ-025 Inputs SHALL be sampled only at the accepted start edge; later changes to the inputs have no effect on the operation.
REQ-026 Intermediate digits MAY appear on diff_4digit during SUB; consumers SHALL qualify the result with done.

Reset
REQ-027 When rst=1 at a clock edge:
  - state = IDLE;
  - busy = 0, done = 0, bout = 0, err = 0;
  - diff_4digit = 16'h0000;
  - all internal registers cleared.
REQ-028 rst SHALL take priority over start and over any in-progress operation; an operation aborted by reset produces no done pulse.

Verification
REQ-029 a=16'h5000, b=16'h1234, bin=0, start pulse -> done 5 cycles later; diff=16'h3766, bout=0, err=0.
REQ-030 a=16'h1234, b=16'h5000, bin=0 -> diff=16'h6234, bout=1.
REQ-031 a=16'h0000, b=16'h0000, bin=1 -> diff=16'h9999, bout=1; and a=16'h9999, b=16'h9999, bin=0 -> diff=16'h0000, bout=0.
REQ-032 a=16'h0A00, b=16'h0001 -> err=1, diff=16'h0000, bout=0, done at the normal latency.
REQ-033 A second start during SUB with different operands -> ignored; the first result is returned and done pulses exactly once.
REQ-034 rst asserted in the second SUB cycle -> next cycle busy=0, diff=16'h0000, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_serial_subtractor_4digit.sv
// rtl/bcd_serial_subtractor_4digit.sv - digit-serial 4-digit BCD subtractor (a - b - bin)
module bcd_serial_subtractor_4digit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a_4digit,
  input  logic [15:0] b_4digit,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff_4digit,
  output logic        bout,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] a_q, b_q;
  logic        borrow_q;
  logic [1:0]  idx_q;

  logic [3:0]  a_digit, b_digit, diff_digit;
  logic [4:0]  raw;
  logic        digit_borrow;

  function automatic logic has_bad_digit(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Even with invalid digits (0..15) the 5-bit difference stays in -16..15,
  // so bit 4 is a reliable sign; adding 10 mod 16 folds a negative digit back.
  always_comb begin
    a_digit      = a_q[{idx_q, 2'b00} +: 4];
    b_digit      = b_q[{idx_q, 2'b00} +: 4];
    raw          = {1'b0, a_digit} - {1'b0, b_digit} - {4'b0000, borrow_q};
    digit_borrow = raw[4];
    diff_digit   = digit_borrow ? (raw[3:0] + 4'd10) : raw[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SUB;
      SUB:     if (idx_q == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      done        <= 1'b0;
      diff_4digit <= '0;
      bout        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a_4digit;
            b_q      <= b_4digit;
            borrow_q <= bin;
            idx_q    <= '0;
            err      <= has_bad_digit(a_4digit) || has_bad_digit(b_4digit);
          end
        end
        SUB: begin
          diff_4digit[{idx_q, 2'b00} +: 4] <= diff_digit;
          borrow_q <= digit_borrow;
          idx_q    <= idx_q + 2'd1;
        end
        DONE: begin
          done <= 1'b1;
          if (err) begin
            diff_4digit <= '0;
            bout        <= 1'b0;
          end else begin
            bout <= borrow_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor_4digit.sv
// tb/tb_bcd_serial_subtractor_4digit.sv - self-checking bench for bcd_serial_subtractor_4digit
module tb_bcd_serial_subtractor_4digit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_4digit, b_4digit;
  logic        bin;
  logic        busy, done, bout, err;
  logic [15:0] diff_4digit;

  int errors = 0;
  int checks = 0;

  bcd_serial_subtractor_4digit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_4digit    (a_4digit),
    .b_4digit    (b_4digit),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .diff_4digit (diff_4digit),
    .bout        (bout),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-number arithmetic on decimal values, ten's complement on underflow.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin_i,
                                output logic [15:0] d, output logic bo, output logic e);
    int av, bv, r;
    logic [15:0] x;
    e = 1'b0;
    av = 0;
    bv = 0;
    for (int i = 3; i >= 0; i--) begin
      x = a >> (i * 4);
      if (x[3:0] > 4'd9) e = 1'b1;
      av = av * 10 + int'(x[3:0]);
      x = b >> (i * 4);
      if (x[3:0] > 4'd9) e = 1'b1;
      bv = bv * 10 + int'(x[3:0]);
    end
    if (e) begin
      d  = 16'h0000;
      bo = 1'b0;
      return;
    end
    r  = av - bv - int'(bin_i);
    bo = (r < 0);
    if (r < 0) r += 10000;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d = d | (16'(r % 10) << (i * 4));
      r = r / 10;
    end
  endfunction

  // One operation: start pulse, inputs scrambled afterwards, optional
  // second start during SUB, then latency / result / single-pulse / hold checks.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic bin_i, input logic restart);
    logic [15:0] ed;
    logic        eb, ee;
    int          k, extra;
    model(a, b, bin_i, ed, eb, ee);
    @(negedge clk);
    a_4digit = a;
    b_4digit = b;
    bin      = bin_i;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a_4digit = 16'($urandom);
    b_4digit = 16'($urandom);
    bin      = ~bin_i;
    check({name, " busy_after_start"}, 32'(busy), 32'd1);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (restart && k == 1) begin
        start    = 1'b1;
        a_4digit = 16'h9876;
        b_4digit = 16'h0123;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    check({name, " latency"}, 32'(k), 32'd5);
    check({name, " diff"}, 32'(diff_4digit), 32'(ed));
    check({name, " bout"}, 32'(bout), 32'(eb));
    check({name, " err"}, 32'(err), 32'(ee));
    extra = 0;
    for (int i = 0; i < (restart ? 8 : 2); i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({name, " single_done"}, 32'(extra), 32'd0);
    check({name, " hold_diff"}, 32'(diff_4digit), 32'(ed));
    check({name, " hold_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          nd;

    vecs[0] = '{16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h5000, 1'b0, 16'h6234, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h0A00, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h000F, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a_4digit = 16'h5555;
    b_4digit = 16'h1111;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff_4digit), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset err", 32'(err), 32'd0);
    start = 1'b1;
    @(negedge clk);
    check("reset over start", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle no start", 32'(busy), 32'd0);

    // Table vectors: compare the DUT with the hand-written expectations,
    // and the reference model with the same expectations.
    for (int i = 0; i < 7; i++) begin
      logic [15:0] md;
      logic        mb, me;
      model(vecs[i].a, vecs[i].b, vecs[i].bin, md, mb, me);
      check($sformatf("model_vec%0d", i), {15'd0, me, mb, md}, {15'd0, vecs[i].err, vecs[i].bout, vecs[i].diff});
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0);
    end

    run_op("restart_ignored", 16'h5000, 16'h1234, 1'b0, 1'b1);

    // Reset during the second SUB cycle aborts without a done pulse.
    @(negedge clk);
    a_4digit = 16'h4321;
    b_4digit = 16'h1234;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort diff", 32'(diff_4digit), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no_done", 32'(nd), 32'd0);
    run_op("after_abort", 16'h4321, 16'h1234, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int j = 0; j < 4; j++) begin
          ra[j*4 +: 4] = 4'($urandom_range(0, 9));
          rb[j*4 +: 4] = 4'($urandom_range(0, 9));
        end
      end
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
